// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampling UART receiver feeding a first-word-fall-through receive FIFO.
// Define UART_RX_PARITY_EN to expect one even-parity bit between the data bits and the stop bit.
module uart_rx_fifo #(
    parameter int unsigned WIDTH_DATA = 8,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx,
    output logic [WIDTH_DATA-1:0] o_data,
    output logic                  o_rdy,
    input  logic                  i_re,
    output logic                  o_full,
    output logic                  o_ferr,
    output logic                  o_ovf,
    output logic                  o_perr
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IdxW = (WIDTH_DATA > 1) ? $clog2(WIDTH_DATA) : 1;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e                state_q, state_d;
    logic                  rx_meta_q, rx_sync_q;
    logic [DivW-1:0]       div_q;
    logic [3:0]            cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [WIDTH_DATA-1:0] shift_q, shift_d;
    logic [1:0]            samp_q, samp_d;
    logic                  armed_q, armed_d;
    logic                  ferr_q, ferr_d;
    logic                  ovf_q, ovf_d;
    logic                  tick, vote, bad_par, push_req, push, pop, full;
    logic [PtrW-1:0]       wr_q, rd_q;
    logic [CntW-1:0]       count_q;
    logic [WIDTH_DATA-1:0] mem_q [FIFO_DEPTH];

    assign tick = (div_q == DivW'(CLK_DIV - 1));
    // Majority of the samples taken at counts 7 and 8 plus the live one at count 9.
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) | (samp_q[1] & rx_sync_q);

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d, perr_q, perr_d;
    assign bad_par = ^{shift_q, par_q};
    assign o_perr  = perr_q;
`else
    assign bad_par = 1'b0;
    assign o_perr  = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        samp_d   = samp_q;
        armed_d  = armed_q;
        push_req = 1'b0;
        ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
        perr_d   = 1'b0;
`endif
        if (tick) begin
            if (state_q != StIdle) begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) samp_d[0] = rx_sync_q;
                if (cnt_q == 4'd8) samp_d[1] = rx_sync_q;
            end
            case (state_q)
                StIdle: begin
                    // A start is only accepted once the line has been seen idle-high.
                    if (rx_sync_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = StStart;
                        cnt_d   = 4'd0;
                        armed_d = 1'b0;
                    end
                end
                StStart: begin
                    if (cnt_q == 4'd9 && vote) begin
                        state_d = StIdle;
                    end else if (cnt_q == 4'd15) begin
                        state_d = StData;
                        idx_d   = '0;
                    end
                end
                StData: begin
                    if (cnt_q == 4'd9) shift_d[idx_q] = vote;
                    if (cnt_q == 4'd15) begin
                        idx_d = idx_q + IdxW'(1);
                        if (idx_q == IdxW'(WIDTH_DATA - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (cnt_q == 4'd9) par_d = vote;
                    if (cnt_q == 4'd15) state_d = StStop;
                end
`endif
                StStop: begin
                    // Leave at the mid-bit decision so the next start edge is never missed.
                    if (cnt_q == 4'd9) begin
                        state_d = StIdle;
                        if (vote) push_req = !bad_par;
                        else      ferr_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d = bad_par;
`endif
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign full  = (count_q == CntW'(FIFO_DEPTH));
    assign pop   = i_re && o_rdy;
    assign push  = push_req && (!full || pop);
    assign ovf_d = push_req && full && !pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            div_q     <= '0;
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            samp_q    <= '0;
            armed_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= i_rx;
            rx_sync_q <= rx_meta_q;
            div_q     <= tick ? '0 : div_q + DivW'(1);
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            samp_q    <= samp_d;
            armed_q   <= armed_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
            if (push) wr_q <= wr_q + PtrW'(1);
            if (pop)  rd_q <= rd_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_q] <= shift_q;
    end

    assign o_rdy  = (count_q != '0);
    assign o_full = full;
    assign o_data = o_rdy ? mem_q[rd_q] : '0;
    assign o_ferr = ferr_q;
    assign o_ovf  = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized frame stimulus checked against a queue-based receive model.
// Honours UART_RX_PARITY_EN the same way the design does.
module tb_uart_rx_fifo;

    localparam int DEPTH = 4;
    localparam int BIT   = 64;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       re  = 1'b0;
    logic [7:0] data;
    logic       rdy, full, ferr, ovf, perr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_ferr = 0, n_ovf = 0, n_perr = 0, n_long = 0;
    int exp_ferr = 0, exp_ovf = 0, exp_perr = 0;
    logic ferr_prev = 1'b0, ovf_prev = 1'b0, perr_prev = 1'b0;
    logic [7:0] model_q[$];

    uart_rx_fifo #(
        .WIDTH_DATA(8),
        .CLK_DIV   (4),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .i_rx  (rx),
        .o_data(data),
        .o_rdy (rdy),
        .i_re  (re),
        .o_full(full),
        .o_ferr(ferr),
        .o_ovf (ovf),
        .o_perr(perr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Count error pulses and any pulse that lasts longer than one clock.
    always @(negedge clk) begin
        if (ferr) n_ferr++;
        if (ovf)  n_ovf++;
        if (perr) n_perr++;
        if ((ferr && ferr_prev) || (ovf && ovf_prev) || (perr && perr_prev)) n_long++;
        ferr_prev = ferr;
        ovf_prev  = ovf;
        perr_prev = perr;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR != 0) drive_bit((^d) ^ !par_ok);
        drive_bit(stop_ok);
        rx = 1'b1;
        if (!stop_ok) exp_ferr++;
        if (PAR != 0 && !par_ok) exp_perr++;
        if (stop_ok && (par_ok || PAR == 0)) begin
            if (model_q.size() < DEPTH) model_q.push_back(d);
            else exp_ovf++;
        end
    endtask

    task automatic check_state(input string tag);
        check_value($sformatf("%s_rdy", tag), {31'd0, rdy}, {31'd0, model_q.size() != 0});
        check_value($sformatf("%s_full", tag), {31'd0, full}, {31'd0, model_q.size() == DEPTH});
        if (model_q.size() != 0) check_value($sformatf("%s_data", tag), {24'd0, data}, {24'd0, model_q[0]});
        check_value($sformatf("%s_nferr", tag), n_ferr, exp_ferr);
        check_value($sformatf("%s_novf", tag), n_ovf, exp_ovf);
        check_value($sformatf("%s_nperr", tag), n_perr, exp_perr);
    endtask

    task automatic pop_check(input string tag);
        if (model_q.size() == 0) begin
            check_value($sformatf("%s_empty", tag), {31'd0, rdy}, 32'd0);
        end else begin
            check_value($sformatf("%s_rdy", tag), {31'd0, rdy}, 32'd1);
            check_value($sformatf("%s_data", tag), {24'd0, data}, {24'd0, model_q[0]});
            void'(model_q.pop_front());
        end
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t0, lat, nrd;
        bit sok, pok;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_value("rst_rdy", {31'd0, rdy}, 32'd0);
        check_value("rst_full", {31'd0, full}, 32'd0);
        check_value("rst_data", {24'd0, data}, 32'd0);
        check_value("rst_flags", {29'd0, ferr, ovf, perr}, 32'd0);
        idle(100);

        // Latency of a single frame from the start edge.
        t0 = cyc;
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            begin
                for (int k = 0; k < 1000; k++) begin
                    @(negedge clk);
                    if (rdy) break;
                end
                lat = cyc - t0;
            end
        join
        check_value("lat_window", {31'd0, (lat >= 600 + BIT * PAR) && (lat <= 620 + BIT * PAR)}, 32'd1);
        check_state("a5");
        pop_check("a5_pop");
        check_value("a5_after_pop", {31'd0, rdy}, 32'd0);
        pop_check("empty_re");
        check_value("empty_re_rdy", {31'd0, rdy}, 32'd0);
        idle(50);

        // Overflow: five frames back-to-back, no reads.
        for (int i = 1; i <= 5; i++) begin
            send_frame(i[7:0], 1'b1, 1'b1);
            if (i == 4) check_value("full_after4", {31'd0, full}, 32'd1);
        end
        idle(20);
        check_state("ovf");
        for (int i = 0; i < 5; i++) pop_check("ovf_pop");

        // Framing error then recovery.
        idle(50);
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(BIT);
        check_state("ferr");
        send_frame(8'h5A, 1'b1, 1'b1);
        idle(20);
        check_state("after_ferr");
        pop_check("5a_pop");

        // Short low glitch on an idle line.
        rx = 1'b0;
        repeat (20) @(negedge clk);
        idle(200);
        check_state("glitch");
        send_frame(8'h7E, 1'b1, 1'b1);
        idle(20);
        check_state("after_glitch");
        pop_check("7e_pop");

        // Reset in the middle of a frame while the FIFO holds two bytes.
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        idle(20);
        check_state("pre_rst");
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        check_value("midrst_rdy", {31'd0, rdy}, 32'd0);
        check_value("midrst_full", {31'd0, full}, 32'd0);
        check_value("midrst_data", {24'd0, data}, 32'd0);
        check_value("midrst_flags", {29'd0, ferr, ovf, perr}, 32'd0);
        idle(BIT * (6 + PAR));
        check_state("post_rst");
        send_frame(8'h81, 1'b1, 1'b1);
        idle(20);
        check_state("after_rst");
        pop_check("81_pop");

        if (PAR != 0) begin
            send_frame(8'h03, 1'b1, 1'b0);
            idle(20);
            check_state("par_bad");
            send_frame(8'h03, 1'b1, 1'b1);
            idle(20);
            check_state("par_good");
            pop_check("par_pop");
        end

        // Random frames, errors, gaps and reads.
        for (int f = 0; f < 24; f++) begin
            b   = 8'($urandom);
            sok = ($urandom_range(7) != 0);
            pok = (PAR == 0) || ($urandom_range(7) != 0);
            send_frame(b, sok, pok);
            idle(20 + $urandom_range(40) + (sok ? 0 : BIT));
            check_state("rnd");
            nrd = $urandom_range(2);
            for (int r = 0; r < nrd; r++) pop_check("rnd_pop");
        end
        while (model_q.size() != 0) pop_check("drain");
        check_value("drain_rdy", {31'd0, rdy}, 32'd0);
        check_value("pulse_width", n_long, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
